// File: rtl/pipe_pkg.sv
// Shared definitions for the stage-boundary skid registers: FSM encoding and the
// default bubble payload inserted on a flush.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // RV32I canonical NOP (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/skid_slot.sv
// WIDTH-wide storage register with load enable and a synchronous clear to INIT.
module skid_slot #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= INIT;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer and
// synchronous flush that leaves a bubble payload on the output.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(NOP_INSN)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_VAL,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_VAL,
  input  logic             FLUSH,
  output logic [1:0]       OCC
);

  state_e           state_q;
  state_e           state_d;
  logic             in_fire;
  logic             out_fire;
  logic             main_load;
  logic             main_from_skid;
  logic             skid_load;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  assign in_fire  = IN_VALID & IN_READY;
  assign out_fire = OUT_VALID & OUT_READY;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath load decode.
  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          state_d   = ST_FULL;
        end
      end
      ST_FULL: begin
        if (in_fire && !out_fire) begin
          skid_load = 1'b1;
          state_d   = ST_SKID;
        end else if (in_fire) begin
          main_load = 1'b1;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (out_fire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Squash: any accepted input is dropped and the bubble overwrites main.
    if (FLUSH) begin
      state_d   = ST_EMPTY;
      main_load = 1'b1;
      skid_load = 1'b0;
    end
  end

  // Outputs depend on the state register only, so IN_READY has no path from OUT_READY.
  always_comb begin
    OUT_VALID = 1'b0;
    IN_READY  = 1'b1;
    OCC       = 2'd0;
    unique case (state_q)
      ST_EMPTY: begin
        OUT_VALID = 1'b0;
        IN_READY  = 1'b1;
        OCC       = 2'd0;
      end
      ST_FULL: begin
        OUT_VALID = 1'b1;
        IN_READY  = 1'b1;
        OCC       = 2'd1;
      end
      ST_SKID: begin
        OUT_VALID = 1'b1;
        IN_READY  = 1'b0;
        OCC       = 2'd2;
      end
      default: begin
        OUT_VALID = 1'b0;
        IN_READY  = 1'b1;
        OCC       = 2'd0;
      end
    endcase
  end

  assign main_d = FLUSH          ? BUBBLE_VAL :
                  main_from_skid ? skid_q     : IN_VAL;

  skid_slot #(
    .WIDTH (WIDTH),
    .INIT  (RESET_VAL)
  ) u_main (
    .clk  (CLK),
    .clr  (RST),
    .load (main_load),
    .d    (main_d),
    .q    (OUT_VAL)
  );

  skid_slot #(
    .WIDTH (WIDTH),
    .INIT  ('0)
  ) u_skid (
    .clk  (CLK),
    .clr  (RST),
    .load (skid_load),
    .d    (IN_VAL),
    .q    (skid_q)
  );

endmodule
